vga_ram_arb: RTL
================

// Module: vga_ram_arb
// PURPOSE
//  Single-port frame-RAM arbiter for the VGA frame buffer. Shares one synchronous
//  RAM port between the scanout reader (hard real-time, absolute priority) and the
//  UART command writer (best effort). Writer traffic is absorbed by a small write FIFO
//  and drained into cycles the scanout leaves free; starvation is flagged, never hidden.
// PARAMETERS
//  AW          13  RAM address width (word = one pixel)
//  DW          6   RAM data width ({r[1:0],g[1:0],b[1:0]})
//  FIFO_DEPTH  4   write FIFO entries; power of 2, >=2
//  STARVE_MAX  64  consecutive denied cycles with FIFO non-empty before o_starve sets
// PORTS
//  i_clk        in   1   system clock (12 MHz)
//  i_nrst       in   1   asynchronous active-low reset
//  i_rd_req     in   1   scanout read strobe, one word per high cycle
//  i_rd_addr    in   AW  scanout read address
//  o_rd_valid   out  1   o_rd_data valid this cycle
//  o_rd_data    out  DW  read data (= i_ram_rdata)
//  i_wr_valid   in   1   writer offers a word
//  i_wr_addr    in   AW  writer address
//  i_wr_data    in   DW  writer data
//  o_wr_ready   out  1   FIFO can accept; transfer = i_wr_valid & o_wr_ready
//  o_busy       out  1   FIFO non-empty (writes pending)
//  o_starve     out  1   sticky starvation flag
//  i_starve_clr in   1   clears o_starve
//  o_ram_en     out  1   RAM port enable
//  o_ram_we     out  1   RAM write enable (valid with o_ram_en)
//  o_ram_addr   out  AW  RAM address
//  o_ram_wdata  out  DW  RAM write data
//  i_ram_rdata  in   DW  RAM read data, valid cycle after a read command
// BEHAVIOUR
//  Reset (i_nrst=0, async): FIFO empty, o_rd_valid=0, o_busy=0, o_starve=0,
//   starve counter=0, o_wr_ready=1; RAM port outputs gated: o_ram_en=0, o_ram_we=0.
//  Arbitration (combinational, per cycle):
//   - i_rd_req=1: o_ram_en=1, o_ram_we=0, o_ram_addr=i_rd_addr. FIFO not popped.
//   - else FIFO non-empty: o_ram_en=1, o_ram_we=1, addr/wdata = FIFO head; pop at edge.
//   - else: o_ram_en=0, o_ram_we=0, addr/wdata hold head-slot values (don't care).
//  Read latency fixed 1: o_rd_valid registered = i_rd_req of previous cycle;
//   o_rd_data = i_ram_rdata passthrough. Back-to-back reads every cycle supported.
//  FIFO: o_wr_ready = (count != FIFO_DEPTH), from registered count. Push on accepted
//   transfer. Push and pop same cycle: count unchanged. Full: ready=0 even if a pop
//   occurs that cycle (no combinational ready path). Pointers wrap mod FIFO_DEPTH.
//   Accepted word committed to RAM no earlier than the next cycle; order preserved.
//  No read/write forwarding: a read of an address with a pending FIFO write returns
//   the old RAM contents. Writer must tolerate one-frame staleness.
//  Starvation: counter increments each cycle FIFO non-empty and i_rd_req=1; clears on
//   any write grant or when FIFO empty; saturates at STARVE_MAX. Reaching STARVE_MAX
//   sets o_starve. i_starve_clr clears o_starve next edge; if set condition and clear
//   coincide, set wins.
//  Reset mid-operation: pending FIFO writes discarded; an in-flight read's o_rd_valid
//   is dropped; RAM port idle until first request after release.
// TESTING
//  1 Reset then idle: o_wr_ready=1, o_busy=0, o_ram_en=0, o_starve=0 for 100 cycles.
//  2 Single write 0x2A@0x0010, no reads -> next cycle o_ram_we=1 addr 0x0010 data 0x2A;
//    read 0x0010 later -> o_rd_valid one cycle after strobe, o_rd_data=0x2A.
//  3 i_rd_req held 10 cycles, 5 writes offered -> 4 accepted, o_wr_ready=0 at full,
//    zero RAM writes during reads; on release writes drain in order, one per cycle.
//  4 Reads continuous 70 cycles with FIFO non-empty -> o_starve=1 at denied cycle 64;
//    i_starve_clr pulse with reads stopped -> o_starve=0 next cycle.
//  5 Full FIFO, simultaneous pop and i_wr_valid -> no push that cycle; count 3 after.
//  6 Assert i_nrst low with 3 pending writes and a read in flight -> o_busy=0,
//    o_rd_valid=0 immediately; no RAM write issued after release.

Source files
------------

// File: rtl/vga_ram_arb.sv
`default_nettype none
// ============================================================================
// Module  : vga_ram_arb
// Brief   : Single-port frame-RAM arbiter; scanout reads have absolute
//           priority, writer traffic drains from a small FIFO into idle slots.
// Revision: 1.0
// ============================================================================
module vga_ram_arb #(
  parameter int AW         = 13,
  parameter int DW         = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 64
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          i_rd_req,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rd_valid,
  output logic [DW-1:0] o_rd_data,
  input  logic          i_wr_valid,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_wr_ready,
  output logic          o_busy,
  output logic          o_starve,
  input  logic          i_starve_clr,
  output logic          o_ram_en,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] c_full_count = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] c_starve_max = SW'(STARVE_MAX);

  logic [AW-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_rd_valid;
  logic [SW-1:0] r_starve_cnt;
  logic [SW-1:0] w_starve_nxt;
  logic          r_starve;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_starve_set;

  assign w_empty    = (r_count == '0);
  // Ready comes only from the registered count, so a full FIFO refuses even
  // in a cycle where it pops.
  assign o_wr_ready = (r_count != c_full_count);
  assign w_push     = i_wr_valid & o_wr_ready;
  assign w_pop      = ~i_rd_req & ~w_empty;
  assign o_busy     = ~w_empty;

  // RAM port is forced idle while reset is held, even if a read is requested.
  assign o_ram_en    = i_nrst & (i_rd_req | ~w_empty);
  assign o_ram_we    = i_nrst & w_pop;
  assign o_ram_addr  = i_rd_req ? i_rd_addr : r_fifo_addr[r_rptr];
  assign o_ram_wdata = r_fifo_data[r_rptr];

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = i_ram_rdata;
  assign o_starve   = r_starve;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= i_wr_addr;
      r_fifo_data[r_wptr] <= i_wr_data;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count    <= w_count_nxt;
      r_rd_valid <= i_rd_req;
    end
  end

  // A non-empty FIFO without a write grant means a read displaced it.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_empty || w_pop) begin
      w_starve_nxt = '0;
    end else if (r_starve_cnt != c_starve_max) begin
      w_starve_nxt = r_starve_cnt + SW'(1);
    end
  end

  assign w_starve_set = (w_starve_nxt == c_starve_max);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_starve_cnt <= '0;
      r_starve     <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      if (w_starve_set) begin
        r_starve <= 1'b1;
      end else if (i_starve_clr) begin
        r_starve <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
